frame_buf_reader: RTL and testbench

Single-clock read-side engine for the dual-port frame buffer RAM. It drives one RAM port (enable, address; one-cycle registered read data) to drain a frame of consecutive words from a circular buffer. It presents the frame as a valid/ready word stream with last-beat and byte-keep marking. It sits between the buffer RAM and the MAC/stream side, and is the counterpart of the port that writes frames into the buffer.

---
 rtl/frame_buf_reader.sv | 160 ++++++++++++++++
 tb/tb_frame_buf_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_reader.sv
// Read-side engine that drains a frame from the circular frame buffer RAM into a word stream.
// Optional build macro FRAME_RD_BYTE_LEN_EN: len_i counts bytes and tkeep_o trims the last beat.
module frame_buf_reader #(
    parameter int NumWords  = 1024,
    parameter int DataWidth = 128,
    parameter int ByteWidth = 8,
    parameter int LenWidth  = 16,
    localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [LenWidth-1:0]  len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ram_en_o,
    output logic [AddrWidth-1:0] ram_addr_o,
    input  logic [DataWidth-1:0] ram_rdata_i,
    output logic [DataWidth-1:0] tdata_o,
    output logic [BeWidth-1:0]   tkeep_o,
    output logic                 tlast_o,
    output logic                 tvalid_o,
    input  logic                 tready_i
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [LenWidth-1:0]   words_q, words_d;
    logic                  en_q, en_d;
    logic                  en_last_q, en_last_d;
    logic                  rvalid_q, rlast_q;
    logic [BeWidth-1:0]    lkeep_q, lkeep_d;
    logic [DataWidth-1:0]  mem_q [4];
    logic [3:0]            mlast_q;
    logic [1:0]            wptr_q, rptr_q;
    logic [2:0]            cnt_q;

    logic [LenWidth-1:0]   total_w;
    logic [BeWidth-1:0]    last_keep;
    logic [3:0]            occ;
    logic                  can_issue, push, pop;

`ifdef FRAME_RD_BYTE_LEN_EN
    localparam logic [LenWidth-1:0] BeLen = LenWidth'(BeWidth);
    logic [LenWidth-1:0] rem_w;

    always_comb begin
        rem_w   = len_i % BeLen;
        total_w = len_i / BeLen + LenWidth'(rem_w != '0);
        for (int b = 0; b < BeWidth; b++) begin
            last_keep[b] = (rem_w == '0) || (LenWidth'(b) < rem_w);
        end
    end
`else
    assign total_w   = len_i;
    assign last_keep = '1;
`endif

    // Words still owed to the FIFO: stored, being read, and returning.
    assign occ       = {1'b0, cnt_q} + 4'(en_q) + 4'(rvalid_q);
    assign can_issue = (state_q == S_READ) && (words_q != '0) && (occ < 4'd4);
    assign push      = rvalid_q;
    assign pop       = tvalid_o && tready_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        words_d   = words_q;
        en_d      = 1'b0;
        en_last_d = 1'b0;
        lkeep_d   = lkeep_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    lkeep_d = last_keep;
                    if (total_w == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_READ;
                        addr_d    = base_addr_i;
                        words_d   = total_w - LenWidth'(1);
                        en_d      = 1'b1;
                        en_last_d = (total_w == LenWidth'(1));
                    end
                end
            end
            S_READ: begin
                if (can_issue) begin
                    addr_d    = (addr_q == AddrWidth'(NumWords - 1)) ? '0
                              : addr_q + AddrWidth'(1);
                    words_d   = words_q - LenWidth'(1);
                    en_d      = 1'b1;
                    en_last_d = (words_q == LenWidth'(1));
                end
                if ((words_q == '0) || (can_issue && words_q == LenWidth'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && tlast_o) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            words_q   <= '0;
            en_q      <= 1'b0;
            en_last_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            lkeep_q   <= '0;
            mlast_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            words_q   <= words_d;
            en_q      <= en_d;
            en_last_q <= en_last_d;
            rvalid_q  <= en_q;
            rlast_q   <= en_last_q;
            lkeep_q   <= lkeep_d;
            if (push) begin
                mlast_q[wptr_q] <= rlast_q;
                wptr_q          <= wptr_q + 2'd1;
            end
            if (pop) rptr_q <= rptr_q + 2'd1;
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= ram_rdata_i;
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign ram_en_o   = en_q;
    assign ram_addr_o = addr_q;
    assign tvalid_o   = (cnt_q != 3'd0);
    assign tlast_o    = tvalid_o && mlast_q[rptr_q];
    assign tdata_o    = tvalid_o ? mem_q[rptr_q] : '0;
    assign tkeep_o    = !tvalid_o ? '0 : (tlast_o ? lkeep_q : '1);

endmodule

// File: tb/tb_frame_buf_reader.sv
// Scoreboard bench for frame_buf_reader: RAM model, expected-beat queue, stream monitor.
// Byte-length tests run when FRAME_RD_BYTE_LEN_EN is defined, word-length tests otherwise.
module tb_frame_buf_reader;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [9:0]   base_addr = '0;
    logic [15:0]  len_in = '0;
    logic         busy_o, done_o, ram_en_o, tlast_o, tvalid_o;
    logic [9:0]   ram_addr_o;
    logic [127:0] ram_rdata = '0;
    logic [127:0] tdata_o;
    logic [15:0]  tkeep_o;
    logic         tready = 1'b1;

    logic [127:0] ram [1024];
    int           cyc = 0;
    int           compared = 0;
    int           mismatched = 0;
    int           issued = 0;
    int           popped = 0;
    beat_t        exp_q [$];
    int           en_cyc [$];
    int           en_addr [$];
    int           beat_cyc [$];
    int           done_log [$];
    logic         hold_v = 1'b0;
    logic [127:0] hold_d;
    logic [15:0]  hold_k;
    logic         hold_l;

    frame_buf_reader dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .base_addr_i (base_addr),
        .len_i       (len_in),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ram_en_o    (ram_en_o),
        .ram_addr_o  (ram_addr_o),
        .ram_rdata_i (ram_rdata),
        .tdata_o     (tdata_o),
        .tkeep_o     (tkeep_o),
        .tlast_o     (tlast_o),
        .tvalid_o    (tvalid_o),
        .tready_i    (tready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ram_en_o) ram_rdata <= ram[ram_addr_o];

    function automatic logic [127:0] word_of(input int a);
        return {32'(a), 32'hC0DE0000 ^ 32'(a), ~32'(a), 32'(a) * 32'd3};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic push_beat(input int addr, input logic [15:0] k, input logic l);
        beat_t b;
        b.d = word_of(addr % 1024);
        b.k = k;
        b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic push_frame(input int base, input int n);
        for (int i = 0; i < n; i++) push_beat(base + i, 16'hFFFF, i == n - 1);
    endtask

    task automatic start_frame(input int base, input int len, output int e);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 10'(base);
        len_in = 16'(len);
        @(posedge clk); #1;
        e = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (done_log.size() <= d0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (done_log.size() <= d0) chk("done_timeout", 128'd0, 128'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 128'(busy_o), 128'd0);
        chk({tag, "_done"}, 128'(done_o), 128'd0);
        chk({tag, "_ram_en"}, 128'(ram_en_o), 128'd0);
        chk({tag, "_ram_addr"}, 128'(ram_addr_o), 128'd0);
        chk({tag, "_tvalid"}, 128'(tvalid_o), 128'd0);
        chk({tag, "_tlast"}, 128'(tlast_o), 128'd0);
        chk({tag, "_tdata"}, tdata_o, 128'd0);
        chk({tag, "_tkeep"}, 128'(tkeep_o), 128'd0);
    endtask

    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            exp_q.delete();
            issued = 0;
            popped = 0;
            hold_v = 1'b0;
        end else begin
            if (ram_en_o) begin
                issued++;
                en_cyc.push_back(cyc);
                en_addr.push_back(int'(ram_addr_o));
                chk("credit_limit", 128'((issued - popped) > 4), 128'd0);
            end
            if (hold_v) begin
                chk("stall_valid", 128'(tvalid_o), 128'd1);
                chk("stall_data", tdata_o, hold_d);
                chk("stall_keep", 128'(tkeep_o), 128'(hold_k));
                chk("stall_last", 128'(tlast_o), 128'(hold_l));
            end
            if (tvalid_o && tready) begin
                beat_cyc.push_back(cyc);
                popped++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 128'd1, 128'd0);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", tdata_o, b.d);
                    chk("beat_keep", 128'(tkeep_o), 128'(b.k));
                    chk("beat_last", 128'(tlast_o), 128'(b.l));
                end
            end
            hold_v = tvalid_o && !tready;
            hold_d = tdata_o;
            hold_k = tkeep_o;
            hold_l = tlast_o;
            if (done_o) done_log.push_back(cyc);
        end
    end

    initial begin
        int e, n0, b0, d0, k;
        for (int i = 0; i < 1024; i++) ram[i] = word_of(i);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst");

`ifndef FRAME_RD_BYTE_LEN_EN
        // Basic frame with exact cycle placement
        n0 = en_cyc.size(); b0 = beat_cyc.size(); d0 = done_log.size();
        push_frame(16'h010, 4);
        start_frame(16'h010, 4, e);
        wait_done(d0);
        chk("t1_n_reads", 128'(en_cyc.size() - n0), 128'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_rd_cycle", 128'(en_cyc[n0 + i] - e), 128'(i));
            chk("t1_rd_addr", 128'(en_addr[n0 + i]), 128'(16'h010 + i));
            chk("t1_beat_cycle", 128'(beat_cyc[b0 + i] - e), 128'(i + 2));
        end
        chk("t1_done_cycle", 128'(done_log[d0] - e), 128'd6);
        @(negedge clk);
        chk("t1_busy_low", 128'(busy_o), 128'd0);

        // Address wrap
        n0 = en_cyc.size(); d0 = done_log.size();
        push_frame(10'h3FE, 4);
        start_frame(10'h3FE, 4, e);
        wait_done(d0);
        chk("t2_wrap_a0", 128'(en_addr[n0]), 128'h3FE);
        chk("t2_wrap_a1", 128'(en_addr[n0 + 1]), 128'h3FF);
        chk("t2_wrap_a2", 128'(en_addr[n0 + 2]), 128'h000);
        chk("t2_wrap_a3", 128'(en_addr[n0 + 3]), 128'h001);

        // Back-pressure 1,0,0,1
        b0 = beat_cyc.size(); d0 = done_log.size();
        push_frame(16'h100, 16);
        start_frame(16'h100, 16, e);
        k = 0;
        while (done_log.size() <= d0 && k < 300) begin
            @(posedge clk); #1;
            tready = (k % 4 == 0) || (k % 4 == 3);
            k++;
        end
        if (done_log.size() <= d0) chk("t3_done_timeout", 128'd0, 128'd1);
        tready = 1'b1;
        chk("t3_beats", 128'(beat_cyc.size() - b0), 128'd16);

        // Zero length
        n0 = en_cyc.size(); b0 = beat_cyc.size(); d0 = done_log.size();
        start_frame(16'h055, 0, e);
        wait_done(d0);
        chk("t4_done_cycle", 128'(done_log[d0] - e), 128'd0);
        repeat (4) @(posedge clk);
        chk("t4_no_reads", 128'(en_cyc.size() - n0), 128'd0);
        chk("t4_no_beats", 128'(beat_cyc.size() - b0), 128'd0);

        // Start while busy is ignored
        n0 = en_cyc.size(); d0 = done_log.size();
        push_frame(16'h180, 4);
        start_frame(16'h180, 4, e);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'h200; len_in = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("t5_reads", 128'(en_cyc.size() - n0), 128'd4);
        chk("t5_one_done", 128'(done_log.size() - d0), 128'd1);
        chk("t5_idle", 128'(busy_o), 128'd0);

        // Reset after beat 3 of an 8-word frame
        b0 = beat_cyc.size(); d0 = done_log.size();
        push_frame(16'h040, 8);
        start_frame(16'h040, 8, e);
        k = 0;
        while (beat_cyc.size() < b0 + 3 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (beat_cyc.size() < b0 + 3) chk("t6_beat_timeout", 128'd0, 128'd1);
        #1 rst_n = 1'b0; tready = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6");
        tready = 1'b1;
        repeat (6) @(posedge clk);
        chk("t6_no_done", 128'(done_log.size() - d0), 128'd0);
        b0 = beat_cyc.size(); d0 = done_log.size();
        push_frame(16'h080, 2);
        start_frame(16'h080, 2, e);
        wait_done(d0);
        repeat (4) @(posedge clk);
        chk("t6_fresh_beats", 128'(beat_cyc.size() - b0), 128'd2);
`else
        // Byte-count frames
        b0 = beat_cyc.size(); d0 = done_log.size();
        push_beat(16'h020, 16'hFFFF, 1'b0);
        push_beat(16'h021, 16'hFFFF, 1'b0);
        push_beat(16'h022, 16'h001F, 1'b1);
        start_frame(16'h020, 37, e);
        wait_done(d0);
        chk("b1_beats", 128'(beat_cyc.size() - b0), 128'd3);

        b0 = beat_cyc.size(); d0 = done_log.size();
        push_beat(16'h030, 16'hFFFF, 1'b0);
        push_beat(16'h031, 16'hFFFF, 1'b1);
        start_frame(16'h030, 32, e);
        wait_done(d0);
        chk("b2_beats", 128'(beat_cyc.size() - b0), 128'd2);

        b0 = beat_cyc.size(); d0 = done_log.size();
        start_frame(16'h030, 0, e);
        wait_done(d0);
        chk("b3_done_cycle", 128'(done_log[d0] - e), 128'd0);
        chk("b3_no_beats", 128'(beat_cyc.size() - b0), 128'd0);
`endif

        repeat (5) @(posedge clk);
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
